// File: rtl/pipeline_ctrl_if.sv
// Pipeline-control bundle: hazard/status inputs from the datapath and the
// bar enables, flushes and forwarding flags returned to it.
interface pipeline_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic       dREN_3;
    logic       dWEN_3;
    logic       dREN_2;
    logic [4:0] rt_2;
    logic [4:0] rs_1;
    logic [4:0] rt_1;
    logic       uses_rt_1;
    logic       take_3;
    logic       halt_4;

    logic       pc_en;
    logic       en_1;
    logic       en_2;
    logic       en_3;
    logic       en_4;
    logic       flush_1;
    logic       flush_2;
    logic       flush_3;
    logic       lwForwardA;
    logic       lwForwardB;
    logic       halted;
    logic       mem_timeout;
    logic [1:0] state;

    modport master (
        output ihit, dhit, dREN_3, dWEN_3, dREN_2, rt_2, rs_1, rt_1,
               uses_rt_1, take_3, halt_4,
        input  pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3,
               lwForwardA, lwForwardB, halted, mem_timeout, state
    );

    modport slave (
        input  ihit, dhit, dREN_3, dWEN_3, dREN_2, rt_2, rs_1, rt_1,
               uses_rt_1, take_3, halt_4,
        output pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3,
               lwForwardA, lwForwardB, halted, mem_timeout, state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle bar load/bubble/PC decisions, load-use
// forwarding flags, sticky halt and data-memory wait watchdog.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 7
) (
    input logic            CLK,
    input logic            nRST,
    pipeline_ctrl_if.slave pipe
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DWAIT   = 2'd1,
        LUSTALL = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t        stateQ, stateD;
    logic [CW-1:0] waitCnt, waitCntD;
    logic          dwait, lu, luEntry, timeoutHit;
    logic          pcEn, en1, en2, en3, en4, fl1, fl2, fl3;
    logic          fwdA, fwdB, haltedQ, memTimeoutQ;

    assign dwait = (pipe.dREN_3 | pipe.dWEN_3) & ~pipe.dhit;
    assign lu    = pipe.dREN_2 & (pipe.rt_2 != '0) &
                   ((pipe.rt_2 == pipe.rs_1) | (pipe.uses_rt_1 & (pipe.rt_2 == pipe.rt_1)));

    always_comb begin
        stateD  = stateQ;
        pcEn    = 1'b0;
        en1     = 1'b0;
        en2     = 1'b0;
        en3     = 1'b0;
        en4     = 1'b0;
        fl1     = 1'b0;
        fl2     = 1'b0;
        fl3     = 1'b0;
        luEntry = 1'b0;
        if (!nRST) begin
            stateD = RUN;
        end else if (stateQ == HALTED) begin
            stateD = HALTED;
        end else if (pipe.halt_4) begin
            stateD = HALTED;
        end else if (dwait) begin
            stateD = DWAIT;
        end else if (pipe.take_3) begin
            // squash wins over load-use: the younger instructions are discarded anyway
            stateD = RUN;
            {pcEn, en1, en2, en3, en4} = '1;
            {fl1, fl2, fl3}            = '1;
        end else if (lu) begin
            stateD  = LUSTALL;
            luEntry = 1'b1;
            {en2, en3, en4} = '1;
            fl2     = 1'b1;
        end else if (!pipe.ihit) begin
            stateD = RUN;
            {en1, en2, en3, en4} = '1;
            fl1    = 1'b1;
        end else begin
            stateD = RUN;
            {pcEn, en1, en2, en3, en4} = '1;
        end
    end

    always_comb begin
        waitCntD = '0;
        if (dwait) begin
            waitCntD = (waitCnt == CW'(TIMEOUT)) ? waitCnt : waitCnt + CW'(1);
        end
    end

    assign timeoutHit = dwait && (waitCntD == CW'(TIMEOUT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stateQ      <= RUN;
            waitCnt     <= '0;
            fwdA        <= 1'b0;
            fwdB        <= 1'b0;
            haltedQ     <= 1'b0;
            memTimeoutQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            waitCnt <= waitCntD;
            if (timeoutHit) begin
                memTimeoutQ <= 1'b1;
            end
            if (stateD == HALTED) begin
                haltedQ <= 1'b1;
            end
            // flags survive freezes (en2=0) and drop on the first advance after the stall
            if (luEntry) begin
                fwdA <= (pipe.rt_2 == pipe.rs_1);
                fwdB <= pipe.uses_rt_1 & (pipe.rt_2 == pipe.rt_1);
            end else if (en2) begin
                fwdA <= 1'b0;
                fwdB <= 1'b0;
            end
        end
    end

    assign pipe.pc_en       = pcEn;
    assign pipe.en_1        = en1;
    assign pipe.en_2        = en2;
    assign pipe.en_3        = en3;
    assign pipe.en_4        = en4;
    assign pipe.flush_1     = fl1;
    assign pipe.flush_2     = fl2;
    assign pipe.flush_3     = fl3;
    assign pipe.lwForwardA  = fwdA;
    assign pipe.lwForwardB  = fwdB;
    assign pipe.halted      = haltedQ;
    assign pipe.mem_timeout = memTimeoutQ;
    assign pipe.state       = stateQ;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector bench for pipeline_ctrl: table of hand-computed cycles plus
// sequences for the watchdog boundary and reset during halt/stall.
module tb_pipeline_ctrl;
    localparam logic [7:0] IHIT  = 8'h80;
    localparam logic [7:0] DHIT  = 8'h40;
    localparam logic [7:0] DREN3 = 8'h20;
    localparam logic [7:0] DWEN3 = 8'h10;
    localparam logic [7:0] DREN2 = 8'h08;
    localparam logic [7:0] TAKE  = 8'h04;
    localparam logic [7:0] HALT  = 8'h02;
    localparam logic [7:0] USERT = 8'h01;

    typedef struct {
        logic [7:0] ctl;
        logic [4:0] rt2;
        logic [4:0] rs1;
        logic [4:0] rt1;
        logic       pe;
        logic [3:0] en;
        logic [2:0] fl;
        logic [1:0] fwd;
        logic       hlt;
        logic       mto;
        logic [1:0] st;
    } vec_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    pipeline_ctrl_if pipe ();

    pipeline_ctrl #(.TIMEOUT(64), .CW(7)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .pipe (pipe)
    );

    int compared   = 0;
    int mismatched = 0;

    // {pc_en, en_1..en_4, flush_1..flush_3, lwForwardA, lwForwardB, halted, mem_timeout, state}
    logic [13:0] obs;
    assign obs = {pipe.pc_en, pipe.en_1, pipe.en_2, pipe.en_3, pipe.en_4,
                  pipe.flush_1, pipe.flush_2, pipe.flush_3,
                  pipe.lwForwardA, pipe.lwForwardB, pipe.halted, pipe.mem_timeout,
                  pipe.state};

    function automatic logic [13:0] mk(logic pe, logic [3:0] en, logic [2:0] fl,
                                       logic [1:0] fwd, logic hlt, logic mto, logic [1:0] st);
        return {pe, en, fl, fwd, hlt, mto, st};
    endfunction

    task automatic apply(input logic [7:0] ctl, input logic [4:0] rt2,
                         input logic [4:0] rs1, input logic [4:0] rt1);
        pipe.ihit      = ctl[7];
        pipe.dhit      = ctl[6];
        pipe.dREN_3    = ctl[5];
        pipe.dWEN_3    = ctl[4];
        pipe.dREN_2    = ctl[3];
        pipe.take_3    = ctl[2];
        pipe.halt_4    = ctl[1];
        pipe.uses_rt_1 = ctl[0];
        pipe.rt_2      = rt2;
        pipe.rs_1      = rs1;
        pipe.rt_1      = rt1;
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b (pe en fl fwd h mto st)", name, act, exp);
        end
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{IHIT,                 5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{IHIT|DREN2,           5'd8, 5'd8, 5'd3, 1'b0, 4'b0111, 3'b010, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{IHIT,                 5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b000, 2'b10, 1'b0, 1'b0, 2'd2};
        vecs[3]  = '{IHIT,                 5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{IHIT|DREN2|USERT,     5'd5, 5'd1, 5'd5, 1'b0, 4'b0111, 3'b010, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{IHIT|DREN3,           5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b01, 1'b0, 1'b0, 2'd2};
        vecs[6]  = '{IHIT|DREN3|DHIT,      5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b000, 2'b01, 1'b0, 1'b0, 2'd1};
        vecs[7]  = '{IHIT,                 5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{IHIT|DREN2|USERT,     5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{IHIT|DREN2,           5'd7, 5'd2, 5'd7, 1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{IHIT|TAKE|DREN2,      5'd8, 5'd8, 5'd0, 1'b1, 4'b1111, 3'b111, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{IHIT,                 5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{8'h00,                5'd0, 5'd0, 5'd0, 1'b0, 4'b1111, 3'b100, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[13] = '{DWEN3,                5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[14] = '{DWEN3|TAKE,           5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 2'd1};
        vecs[15] = '{DWEN3|DHIT|TAKE,      5'd0, 5'd0, 5'd0, 1'b1, 4'b1111, 3'b111, 2'b00, 1'b0, 1'b0, 2'd1};
        vecs[16] = '{IHIT|HALT|DREN3,      5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0};
        vecs[17] = '{IHIT,                 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b1, 1'b0, 2'd3};
        vecs[18] = '{IHIT|TAKE,            5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 1'b1, 1'b0, 2'd3};

        apply(IHIT, 5'd0, 5'd0, 5'd0);
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check("reset", obs, 14'b0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            apply(vecs[i].ctl, vecs[i].rt2, vecs[i].rs1, vecs[i].rt1);
            #1;
            check($sformatf("vec%0d", i), obs,
                  mk(vecs[i].pe, vecs[i].en, vecs[i].fl, vecs[i].fwd,
                     vecs[i].hlt, vecs[i].mto, vecs[i].st));
        end

        // asynchronous reset while halted
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("rst_in_halt", obs, 14'b0);
        @(negedge CLK);
        nRST = 1'b1;
        apply(IHIT, 5'd0, 5'd0, 5'd0);
        #1;
        check("run_after_halt", obs, mk(1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0));

        // 64 consecutive wait cycles: flag must stay low until the 64th has been counted
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            apply(IHIT|DREN3, 5'd0, 5'd0, 5'd0);
            #1;
            check($sformatf("wait%0d", i), obs,
                  mk(1'b0, 4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, (i == 0) ? 2'd0 : 2'd1));
        end
        @(negedge CLK);
        apply(IHIT|DREN3|DHIT, 5'd0, 5'd0, 5'd0);
        #1;
        check("timeout_set", obs, mk(1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b1, 2'd1));
        @(negedge CLK);
        apply(IHIT, 5'd0, 5'd0, 5'd0);
        #1;
        check("timeout_sticky", obs, mk(1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b1, 2'd0));

        // reset landing in the load-use stall cycle
        @(negedge CLK);
        apply(IHIT|DREN2|USERT, 5'd9, 5'd9, 5'd9);
        #1;
        check("lu_both", obs, mk(1'b0, 4'b0111, 3'b010, 2'b00, 1'b0, 1'b1, 2'd0));
        @(negedge CLK);
        apply(IHIT, 5'd0, 5'd0, 5'd0);
        #1;
        check("lu_flags", obs, mk(1'b1, 4'b1111, 3'b000, 2'b11, 1'b0, 1'b1, 2'd2));
        #1;
        nRST = 1'b0;
        #1;
        check("rst_in_stall", obs, 14'b0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("clean_after_rst", obs, mk(1'b1, 4'b1111, 3'b000, 2'b00, 1'b0, 1'b0, 2'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the five-stage pipeline register bars (IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it decides which bars load, which bars take a bubble, and whether the PC advances. The decision covers instruction-fetch misses, data-memory waits, load-use hazards, branch/jump squashes resolved in MEM, and halt. It also produces the registered load-use forwarding flags consumed by the forwarding unit, plus a data-memory wait watchdog.

Parameters:
TIMEOUT, 64, consecutive data-wait cycles before mem_timeout asserts (minimum 2).
CW, 7, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction fetch complete this cycle.
dhit  in  1  data access complete this cycle.
dREN_3  in  1  EX/MEM stage load request.
dWEN_3  in  1  EX/MEM stage store request.
dREN_2  in  1  ID/EX instruction is a load.
rt_2  in  5  load destination register in ID/EX.
rs_1  in  5  rs field of the IF/ID instruction.
rt_1  in  5  rt field of the IF/ID instruction.
uses_rt_1  in  1  IF/ID instruction reads rt.
take_3  in  1  branch taken, j, jal or JR resolved in the EX/MEM stage.
halt_4  in  1  halt at MEM/WB output.
pc_en  out  1  PC load enable.
en_1..en_4  out  1 each  bar load enables (IF/ID..MEM/WB).
flush_1..flush_3  out  1 each  load a bubble (all zeros) into the bar instead of its inputs.
lwForwardA  out  1  registered; rs needs WB-stage forward after a load-use stall.
lwForwardB  out  1  registered; rt needs WB-stage forward after a load-use stall.
halted  out  1  sticky halt indicator.
mem_timeout  out  1  sticky watchdog flag.
state  out  2  FSM state, debug use only.

Behaviour:
- The FSM and counters are registered on posedge CLK and reset asynchronously on nRST low. All en/flush/pc_en outputs are combinational from state and inputs.
- Reset values: state=RUN(0), halted=0, mem_timeout=0, lwForwardA/B=0, wait counter=0. While nRST is low, all en_*, pc_en and flush_* are forced to 0.
- FSM states: RUN=0, DWAIT=1, LUSTALL=2, HALTED=3.
- Derived signals:
  - dwait = (dREN_3|dWEN_3) & ~dhit.
  - lu = dREN_2 & (rt_2!=0) & ((rt_2==rs_1) | (uses_rt_1 & (rt_2==rt_1))).
- Per-cycle action in RUN/DWAIT/LUSTALL, highest priority first:
  1. halt_4: all en=0, pc_en=0, flush=0; next state HALTED.
  2. dwait: all en=0, pc_en=0 (freeze); next state DWAIT.
  3. take_3: en_1..4=1, flush_1=flush_2=flush_3=1, pc_en=1 (PC takes the target). Squash overrides load-use.
  4. lu: pc_en=0, en_1=0, en_2..4=1, flush_2=1; next state LUSTALL.
  5. ~ihit: pc_en=0, en_1=1 with flush_1=1, en_2..4=1.
  6. Otherwise: all en=1, pc_en=1, flushes 0.
- Next state when actions 3, 5 or 6 apply is RUN.
- LUSTALL lasts one advancing cycle. On entry, lwForwardA is set to (rt_2==rs_1) and lwForwardB to (uses_rt_1 & rt_2==rt_1). Both clear on the next cycle in which en_2 is 1 with state≠LUSTALL entry. They are held unchanged during DWAIT.
- DWAIT returns to RUN on dhit; the freeze ends in that same cycle, so bars load.
- Wait counter:
  - Increments in each dwait cycle, saturating at TIMEOUT; clears on any non-dwait cycle.
  - mem_timeout sets when the counter reaches TIMEOUT and stays set until reset.
- HALTED: all en=0, pc_en=0, flush=0, halted=1. The state is exited only by nRST.
- Reset mid-stall clears all state immediately. No residual bubble or forwarding flag survives reset.
- Load-use against $0 never stalls.

Test Plan:
- Reset then ihit=1 steady, no hazards -> pc_en=1, en_1..4=1, flushes 0, state=0, halted=0.
- dREN_2=1, rt_2=8, rs_1=8 -> one cycle pc_en=0, en_1=0, flush_2=1; next cycle lwForwardA=1, lwForwardB=0, state=2; following cycle flags clear.
- dREN_3=1, dhit=0 for 3 cycles then 1 -> en all 0 for 3 cycles with state=1; on dhit bars load and state returns to 0. Repeat with 64 wait cycles -> mem_timeout=1 and stays 1.
- take_3=1 simultaneous with load-use match -> flush_1..3=1, pc_en=1, no stall, lwForward flags stay 0.
- halt_4=1 while dREN_3=1, dhit=0 -> HALTED next cycle, halted=1, all en 0. nRST pulse mid-halt -> halted=0, state=0.
- ihit=0, no other events -> pc_en=0, en_1=1 with flush_1=1, en_2..4=1.
